// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_if
//  Description : Control and display bundle for countdown_timer.
//                master : game controller side (drives load/start/pause and
//                         the BCD load digits, observes time and status)
//                slave  : the timer itself
//  Signals     : load, start, pause, load_decaseconds/seconds/deciseconds (in)
//                decaseconds_out, seconds_out, deciseconds_out, running,
//                at_zero, done_pulse, warn (out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_if;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] load_decaseconds;
  logic [3:0] load_seconds;
  logic [3:0] load_deciseconds;
  logic [3:0] decaseconds_out;
  logic [3:0] seconds_out;
  logic [3:0] deciseconds_out;
  logic       running;
  logic       at_zero;
  logic       done_pulse;
  logic       warn;

  modport master (
    output load, start, pause,
    output load_decaseconds, load_seconds, load_deciseconds,
    input  decaseconds_out, seconds_out, deciseconds_out,
    input  running, at_zero, done_pulse, warn
  );

  modport slave (
    input  load, start, pause,
    input  load_decaseconds, load_seconds, load_deciseconds,
    output decaseconds_out, seconds_out, deciseconds_out,
    output running, at_zero, done_pulse, warn
  );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Down-counting BCD timer (max 99.9 s) for the timed typing
//                test. Counts down in 0.1 s steps derived from a CLK_DIV
//                prescaler and signals expiry to the game controller.
//  Ports       : clk, rst (sync, active-high)
//                bus (countdown_timer_if.slave):
//                  load/start/pause, load_* BCD digits      -> inputs
//                  *_out BCD digits, running, at_zero,
//                  done_pulse, warn                          -> outputs
//  Parameters  : CLK_DIV   - clk cycles per 0.1 s tick
//                WARN_DECI - warn threshold in deciseconds (feature build only)
//  Options     : `define COUNTDOWN_WARN_EN builds the low-time warn output;
//                otherwise warn is tied 0 and no comparator exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int CLK_DIV = 10000000
`ifdef COUNTDOWN_WARN_EN
  ,
  parameter int WARN_DECI = 100
`endif
) (
  input wire logic          clk,
  input wire logic          rst,
  countdown_timer_if.slave  bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] c_presc_max = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_deca, r_sec, r_deci;
  logic [3:0]    w_deca_nxt, w_sec_nxt, w_deci_nxt;
  logic [3:0]    w_dec_deca, w_dec_sec, w_dec_deci;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_running, r_at_zero, r_done_pulse;
  logic          w_done_pulse_nxt;
  logic          w_loaded_zero, w_dec_zero, w_tick;

  function automatic logic [3:0] f_clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign w_loaded_zero = (r_deca == 4'd0) && (r_sec == 4'd0) && (r_deci == 4'd0);
  assign w_tick        = (r_presc == c_presc_max);

  // One-step BCD decrement with borrow; an all-zero value holds.
  always_comb begin
    w_dec_deca = r_deca;
    w_dec_sec  = r_sec;
    w_dec_deci = r_deci;
    if (r_deci != 4'd0) begin
      w_dec_deci = r_deci - 4'd1;
    end else if (r_sec != 4'd0) begin
      w_dec_deci = 4'd9;
      w_dec_sec  = r_sec - 4'd1;
    end else if (r_deca != 4'd0) begin
      w_dec_deci = 4'd9;
      w_dec_sec  = 4'd9;
      w_dec_deca = r_deca - 4'd1;
    end
  end

  assign w_dec_zero = (w_dec_deca == 4'd0) && (w_dec_sec == 4'd0) && (w_dec_deci == 4'd0);

  // Next-state, next-digit and next-prescaler logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_deca_nxt       = r_deca;
    w_sec_nxt        = r_sec;
    w_deci_nxt       = r_deci;
    w_presc_nxt      = r_presc;
    w_done_pulse_nxt = 1'b0;

    if (bus.load) begin
      w_state_nxt = S_IDLE;
      w_deca_nxt  = f_clamp9(bus.load_decaseconds);
      w_sec_nxt   = f_clamp9(bus.load_seconds);
      w_deci_nxt  = f_clamp9(bus.load_deciseconds);
      w_presc_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_presc_nxt = '0;
            if (w_loaded_zero) begin
              w_state_nxt      = S_DONE;
              w_done_pulse_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
            end
          end
        end
        S_RUN: begin
          // pause beats a coincident tick: prescaler and digits freeze as-is
          if (bus.pause) begin
            w_state_nxt = S_PAUSE;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            w_deca_nxt  = w_dec_deca;
            w_sec_nxt   = w_dec_sec;
            w_deci_nxt  = w_dec_deci;
            if (w_dec_zero) begin
              w_state_nxt      = S_DONE;
              w_done_pulse_nxt = 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        S_PAUSE: begin
          if (bus.start && !bus.pause) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_deca       <= 4'd0;
      r_sec        <= 4'd0;
      r_deci       <= 4'd0;
      r_presc      <= '0;
      r_running    <= 1'b0;
      r_at_zero    <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_deca       <= w_deca_nxt;
      r_sec        <= w_sec_nxt;
      r_deci       <= w_deci_nxt;
      r_presc      <= w_presc_nxt;
      r_running    <= (w_state_nxt == S_RUN);
      r_at_zero    <= (w_state_nxt == S_DONE);
      r_done_pulse <= w_done_pulse_nxt;
    end
  end

`ifdef COUNTDOWN_WARN_EN
  logic [9:0] w_remaining_nxt;
  logic       w_warn_nxt;
  logic       r_warn;

  // Evaluated on next-state digits so warn moves on the same edge as them.
  assign w_remaining_nxt = 10'(w_deca_nxt) * 10'd100 + 10'(w_sec_nxt) * 10'd10
                         + 10'(w_deci_nxt);
  assign w_warn_nxt = ((w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE)) &&
                      ($signed({22'd0, w_remaining_nxt}) <= WARN_DECI);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= w_warn_nxt;
    end
  end

  assign bus.warn = r_warn;
`else
  assign bus.warn = 1'b0;
`endif

  assign bus.decaseconds_out = r_deca;
  assign bus.seconds_out     = r_sec;
  assign bus.deciseconds_out = r_deci;
  assign bus.running         = r_running;
  assign bus.at_zero         = r_at_zero;
  assign bus.done_pulse      = r_done_pulse;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Scoreboard bench for countdown_timer. A driver applies
//                directed and random stimulus on the falling edge, advances an
//                integer-deciseconds reference model and queues the expected
//                registered outputs; a monitor pops and compares after every
//                rising edge.
//  Options     : honours `define COUNTDOWN_WARN_EN (WARN_DECI = 10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  localparam int CLK_DIV = 4;
`ifdef COUNTDOWN_WARN_EN
  localparam int WARN_DECI = 10;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  typedef struct packed {
    logic [3:0] deca;
    logic [3:0] sec;
    logic [3:0] deci;
    logic       running;
    logic       at_zero;
    logic       done_pulse;
    logic       warn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_if bus ();

`ifdef COUNTDOWN_WARN_EN
  countdown_timer #(.CLK_DIV(CLK_DIV), .WARN_DECI(WARN_DECI)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`else
  countdown_timer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: remaining time as a plain number of deciseconds.
  int m_mode  = M_IDLE;
  int m_rem   = 0;
  int m_phase = 0;
  bit m_pulse = 1'b0;

  function automatic int clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_step(input bit r, input bit l, input bit s, input bit p,
                            input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c);
    exp_t e;
    m_pulse = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_rem = 0; m_phase = 0;
    end else if (l) begin
      m_rem = clamp9(a) * 100 + clamp9(b) * 10 + clamp9(c);
      m_phase = 0; m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (s) begin
          if (m_rem > 0) begin m_mode = M_RUN; m_phase = 0; end
          else begin m_mode = M_DONE; m_pulse = 1'b1; end
        end
        M_RUN: begin
          if (p) m_mode = M_PAUSED;
          else if (m_phase == CLK_DIV - 1) begin
            m_phase = 0;
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_mode = M_DONE; m_pulse = 1'b1; end
          end else m_phase = m_phase + 1;
        end
        M_PAUSED: if (s && !p) m_mode = M_RUN;
        default: ;
      endcase
    end
    e.deca       = 4'(m_rem / 100);
    e.sec        = 4'((m_rem / 10) % 10);
    e.deci       = 4'(m_rem % 10);
    e.running    = (m_mode == M_RUN);
    e.at_zero    = (m_mode == M_DONE);
    e.done_pulse = m_pulse;
`ifdef COUNTDOWN_WARN_EN
    e.warn = ((m_mode == M_RUN) || (m_mode == M_PAUSED)) && (m_rem <= WARN_DECI);
`else
    e.warn = 1'b0;
`endif
    q_exp.push_back(e);
  endtask

  // Drive one cycle of inputs and queue what the following edge should give.
  task automatic step(input bit r, input bit l, input bit s, input bit p,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c);
    @(negedge clk);
    rst = r;
    bus.load = l; bus.start = s; bus.pause = p;
    bus.load_decaseconds = a; bus.load_seconds = b; bus.load_deciseconds = c;
    model_step(r, l, s, p, a, b, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    step(0, 1, 0, 0, a, b, c);
  endtask

  task automatic start();
    step(0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
  endtask

  // Monitor: every registered output sampled 1 ns after the active edge.
  initial begin
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        act = {bus.decaseconds_out, bus.seconds_out, bus.deciseconds_out,
               bus.running, bus.at_zero, bus.done_pulse, bus.warn};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got %0d/%0d/%0d run=%b zero=%b pulse=%b warn=%b, expected %0d/%0d/%0d run=%b zero=%b pulse=%b warn=%b",
                   $time, act.deca, act.sec, act.deci, act.running, act.at_zero,
                   act.done_pulse, act.warn, e.deca, e.sec, e.deci, e.running,
                   e.at_zero, e.done_pulse, e.warn);
        end
      end
    end
  end

  initial begin
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.load_decaseconds = 4'd0; bus.load_seconds = 4'd0; bus.load_deciseconds = 4'd0;

    // Reset state
    step(1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    step(1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    idle(2);

    // 0.3 s countdown to DONE, then at_zero holds
    load(4'd0, 4'd0, 4'd3);
    start();
    idle(16);

    // 10.0 s: borrow across every digit, runs all the way to DONE
    load(4'd1, 4'd0, 4'd0);
    start();
    idle(100 * CLK_DIV + 4);

    // Pause mid-prescale and resume from the held count
    load(4'd0, 4'd0, 4'd5);
    start();
    idle(6);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 4'd0, 4'd0, 4'd0);
    step(0, 0, 1, 1, 4'd0, 4'd0, 4'd0);
    step(0, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    idle(5 * CLK_DIV);

    // Zero load: immediate DONE, later starts ignored
    load(4'd0, 4'd0, 4'd0);
    start();
    idle(2);
    start();
    step(0, 0, 1, 1, 4'd0, 4'd0, 4'd0);
    idle(2);

    // Clamp and load priority over start
    load(4'd12, 4'd15, 4'd10);
    step(0, 1, 1, 0, 4'd12, 4'd15, 4'd10);
    idle(3);

    // Reset during RUN
    load(4'd0, 4'd4, 4'd2);
    start();
    idle(9);
    step(1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    idle(2);

    // Low-time warning window
    load(4'd0, 4'd1, 4'd2);
    start();
    idle(13 * CLK_DIV);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit r, l, s, p;
      logic [3:0] a, b, c;
      r = ($urandom_range(0, 399) == 0);
      l = ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 9) == 0);
      a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'd0;
      b = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      c = 4'($urandom_range(0, 15));
      step(r, l, s, p, a, b, c);
    end
    idle(2);

    @(posedge clk);
    #2;
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_exp.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
